// File: rtl/halton_reader_pkg.sv
// rtl/halton_reader_pkg.sv - shared types and defaults for the Halton pop reader
package halton_reader_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = 16;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RESEED = 3'd1,
    S_ISSUE  = 3'd2,
    S_WAIT   = 3'd3,
    S_DRAIN  = 3'd4
  } state_t;

  typedef struct packed {
    logic [DEF_CNT_W-1:0] idx;
    logic [DEF_WIDTH-1:0] out_1;
    logic [DEF_WIDTH-1:0] out_0;
  } sample_t;

endpackage

// File: rtl/halton_sample_fifo.sv
// rtl/halton_sample_fifo.sv - synchronous FIFO of captured sample entries
module halton_sample_fifo
  import halton_reader_pkg::*;
#(
  parameter type T     = sample_t,
  parameter int  DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  T                       push_data,
  input  logic                   pop,
  output T                       head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

  T              mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  // storage, pointers and occupancy; DEPTH is a power of two so pointers wrap freely
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/halton_pop_reader.sv
// rtl/halton_pop_reader.sv - pops a Halton generator and streams captured point pairs
module halton_pop_reader
  import halton_reader_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [CNT_W-1:0]   num_samples,
  input  logic               reseed_req,
  input  logic [WIDTH-1:0]   seed_in,
  output logic               gen_pop_enable,
  output logic               gen_reseed_enable,
  output logic [WIDTH-1:0]   gen_seed,
  input  logic               gen_valid,
  input  logic [WIDTH-1:0]   gen_out_0,
  input  logic [WIDTH-1:0]   gen_out_1,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [2*WIDTH-1:0] m_data,
  output logic [CNT_W-1:0]   m_index,
  output logic               busy,
  output logic               done,
  output logic               timeout_err,
  output logic [CNT_W-1:0]   samples_rcvd
);

  typedef struct packed {
    logic [CNT_W-1:0] idx;
    logic [WIDTH-1:0] out_1;
    logic [WIDTH-1:0] out_0;
  } entry_t;

  localparam int CW   = $clog2(FIFO_DEPTH) + 1;
  localparam int WC_W = $clog2(TIMEOUT + 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [CNT_W-1:0] samples_d, samples_inc;
  logic [WC_W-1:0]  wait_q, wait_d;
  logic             terr_d, pop_d, reseed_d, done_d, busy_d;
  logic [WIDTH-1:0] seed_d;
  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0]    fifo_count;
  entry_t           push_entry, fifo_head;

  assign samples_inc = samples_rcvd + CNT_W'(1);
  assign push_entry  = '{idx: samples_inc, out_1: gen_out_1, out_0: gen_out_0};
  assign fifo_pop    = m_valid && m_ready;
  assign m_valid     = !fifo_empty;
  assign m_data      = {fifo_head.out_1, fifo_head.out_0};
  assign m_index     = fifo_head.idx;

  halton_sample_fifo #(.T(entry_t), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // next-state and next-output decode; a pop is only issued when a FIFO slot is free
  always_comb begin
    state_d   = state_q;
    num_d     = num_q;
    samples_d = samples_rcvd;
    wait_d    = wait_q;
    terr_d    = timeout_err;
    seed_d    = gen_seed;
    pop_d     = 1'b0;
    reseed_d  = 1'b0;
    done_d    = 1'b0;
    fifo_push = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          num_d     = num_samples;
          seed_d    = seed_in;
          terr_d    = 1'b0;
          samples_d = '0;
          if (num_samples == '0) begin
            state_d = S_DRAIN;
          end else if (reseed_req) begin
            state_d  = S_RESEED;
            reseed_d = 1'b1;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_RESEED: state_d = S_ISSUE;
      S_ISSUE: begin
        if (fifo_count < CW'(FIFO_DEPTH)) begin
          pop_d   = 1'b1;
          wait_d  = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (gen_valid) begin
          fifo_push = !fifo_full;
          samples_d = samples_inc;
          state_d   = (samples_inc == num_q) ? S_DRAIN : S_ISSUE;
        end else if (wait_q == WC_W'(TIMEOUT - 1)) begin
          terr_d  = 1'b1;
          state_d = S_DRAIN;
        end else begin
          wait_d = wait_q + WC_W'(1);
        end
      end
      S_DRAIN: begin
        if (fifo_empty) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // state, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= S_IDLE;
      num_q             <= '0;
      wait_q            <= '0;
      samples_rcvd      <= '0;
      timeout_err       <= 1'b0;
      gen_seed          <= '0;
      gen_pop_enable    <= 1'b0;
      gen_reseed_enable <= 1'b0;
      done              <= 1'b0;
      busy              <= 1'b0;
    end else begin
      state_q           <= state_d;
      num_q             <= num_d;
      wait_q            <= wait_d;
      samples_rcvd      <= samples_d;
      timeout_err       <= terr_d;
      gen_seed          <= seed_d;
      gen_pop_enable    <= pop_d;
      gen_reseed_enable <= reseed_d;
      done              <= done_d;
      busy              <= busy_d;
    end
  end

endmodule

// File: tb/tb_halton_pop_reader.sv
// tb/tb_halton_pop_reader.sv - directed scoreboard bench for halton_pop_reader
module tb_halton_pop_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] num_samples = '0;
  logic        reseed_req = 1'b0;
  logic [31:0] seed_in = '0;
  logic        gen_pop_enable, gen_reseed_enable, gen_valid;
  logic [31:0] gen_seed, gen_out_0, gen_out_1;
  logic        m_valid, busy, done, timeout_err;
  logic        m_ready = 1'b0;
  logic [63:0] m_data;
  logic [15:0] m_index, samples_rcvd;

  int checks = 0;
  int errors = 0;

  halton_pop_reader dut (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
    .reseed_req(reseed_req), .seed_in(seed_in),
    .gen_pop_enable(gen_pop_enable), .gen_reseed_enable(gen_reseed_enable),
    .gen_seed(gen_seed), .gen_valid(gen_valid), .gen_out_0(gen_out_0),
    .gen_out_1(gen_out_1), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_index(m_index), .busy(busy), .done(done),
    .timeout_err(timeout_err), .samples_rcvd(samples_rcvd)
  );

  always #5 clk = ~clk;

  // generator model: k-th pop returns out_0=k, out_1=100+k, valid two cycles later
  bit          gen_on = 1'b1;
  logic        p0 = 1'b0, p1 = 1'b0;
  logic [31:0] k0 = '0, k1 = '0;
  int          gen_k = 0;
  int          pop_total = 0;
  always @(posedge clk) begin
    p0 <= gen_pop_enable && gen_on;
    k0 <= 32'(gen_k + 1);
    p1 <= p0;
    k1 <= k0;
    if (gen_pop_enable) begin
      gen_k     <= gen_k + 1;
      pop_total <= pop_total + 1;
    end
  end
  assign gen_valid = p1;
  assign gen_out_0 = k1;
  assign gen_out_1 = k1 + 32'd100;

  task automatic check_val(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // stream monitor and scoreboard
  logic [79:0] exp_q[$];
  logic [79:0] hold_val, last_beat, e;
  bit          hold_pend = 1'b0;
  int          beat_cnt = 0, done_cnt = 0, reseed_cnt = 0, reseed_pops = 0;
  logic [31:0] reseed_seed = '0;
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (gen_reseed_enable) begin
      reseed_cnt++;
      reseed_seed = gen_seed;
      reseed_pops = pop_total;
    end
    if (!rst && hold_pend && m_valid) check_val("hold_stable", {m_index, m_data}, hold_val);
    hold_pend = !rst && m_valid && !m_ready;
    hold_val  = {m_index, m_data};
    if (!rst && m_valid && m_ready) begin
      check_val("beat_expected", 80'(exp_q.size() != 0), 80'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_val("beat", {m_index, m_data}, e);
      end
      beat_cnt++;
      last_beat = {m_index, m_data};
    end
  end

  task automatic push_expected(input int n, input int kb);
    for (int i = 1; i <= n; i++)
      exp_q.push_back({16'(i), 32'(kb + i + 100), 32'(kb + i)});
  endtask

  task automatic do_start(input int n, input bit rs, input logic [31:0] sd);
    @(posedge clk); #1;
    start = 1'b1; num_samples = 16'(n); reseed_req = rs; seed_in = sd;
    @(posedge clk); #1;
    start = 1'b0; reseed_req = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int maxc);
    int n = 0;
    while (!done && n < maxc) begin
      @(negedge clk);
      n++;
    end
    check_val(tag, 80'(done), 80'd1);
  endtask

  int pb, db, bb, kb, n;

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_m_valid", 80'(m_valid), 80'd0);
    check_val("rst_busy", 80'(busy), 80'd0);
    check_val("rst_done", 80'(done), 80'd0);
    check_val("rst_terr", 80'(timeout_err), 80'd0);
    check_val("rst_samples", 80'(samples_rcvd), 80'd0);
    check_val("rst_pop", 80'(gen_pop_enable), 80'd0);
    check_val("rst_reseed", 80'(gen_reseed_enable), 80'd0);
    check_val("rst_seed", 80'(gen_seed), 80'd0);
    check_val("rst_data", {m_index, m_data}, 80'd0);
    rst = 1'b0;

    // num=5 with ready consumer
    m_ready = 1'b1; pb = pop_total; db = done_cnt; bb = beat_cnt; kb = gen_k;
    push_expected(5, kb);
    do_start(5, 1'b0, 32'd0);
    wait_done("t1_done", 200);
    repeat (3) @(negedge clk);
    check_val("t1_pops", 80'(pop_total - pb), 80'd5);
    check_val("t1_beats", 80'(beat_cnt - bb), 80'd5);
    check_val("t1_done_cnt", 80'(done_cnt - db), 80'd1);
    check_val("t1_samples", 80'(samples_rcvd), 80'd5);
    check_val("t1_last", last_beat, {16'd5, 32'd105, 32'd5});
    check_val("t1_busy", 80'(busy), 80'd0);

    // num=8 with stalled consumer: credit limits pops to FIFO depth
    m_ready = 1'b0; pb = pop_total; db = done_cnt; bb = beat_cnt; kb = gen_k;
    push_expected(8, kb);
    do_start(8, 1'b0, 32'd0);
    repeat (40) @(negedge clk);
    check_val("t2_stall_pops", 80'(pop_total - pb), 80'd4);
    check_val("t2_stall_busy", 80'(busy), 80'd1);
    check_val("t2_stall_head", {m_index, m_data}, {16'd1, 32'(kb + 101), 32'(kb + 1)});
    check_val("t2_stall_samples", 80'(samples_rcvd), 80'd4);
    @(posedge clk); #1;
    m_ready = 1'b1;
    wait_done("t2_done", 300);
    repeat (3) @(negedge clk);
    check_val("t2_pops", 80'(pop_total - pb), 80'd8);
    check_val("t2_beats", 80'(beat_cnt - bb), 80'd8);
    check_val("t2_done_cnt", 80'(done_cnt - db), 80'd1);
    check_val("t2_queue_empty", 80'(exp_q.size()), 80'd0);

    // silent generator: single pop then timeout
    gen_on = 1'b0; pb = pop_total; db = done_cnt; bb = beat_cnt;
    do_start(3, 1'b0, 32'd0);
    n = 0;
    while (!gen_pop_enable && n < 10) begin
      @(negedge clk);
      n++;
    end
    check_val("t3_pop_seen", 80'(gen_pop_enable), 80'd1);
    n = 0;
    while (!timeout_err && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_val("t3_timeout_latency", 80'(n), 80'd16);
    wait_done("t3_done", 20);
    repeat (3) @(negedge clk);
    check_val("t3_terr", 80'(timeout_err), 80'd1);
    check_val("t3_pops", 80'(pop_total - pb), 80'd1);
    check_val("t3_m_valid", 80'(m_valid), 80'd0);
    check_val("t3_samples", 80'(samples_rcvd), 80'd0);
    check_val("t3_done_cnt", 80'(done_cnt - db), 80'd1);
    gen_on = 1'b1;

    // num=0: straight to DRAIN, done next cycle
    pb = pop_total; db = done_cnt;
    do_start(0, 1'b0, 32'd0);
    @(negedge clk);
    check_val("t4_busy_drain", 80'(busy), 80'd1);
    check_val("t4_done_early", 80'(done), 80'd0);
    check_val("t4_terr_cleared", 80'(timeout_err), 80'd0);
    @(negedge clk);
    check_val("t4_done", 80'(done), 80'd1);
    check_val("t4_busy_idle", 80'(busy), 80'd0);
    repeat (3) @(negedge clk);
    check_val("t4_pops", 80'(pop_total - pb), 80'd0);
    check_val("t4_done_cnt", 80'(done_cnt - db), 80'd1);

    // reseed ahead of the first pop
    pb = pop_total; bb = beat_cnt; kb = gen_k; reseed_cnt = 0;
    push_expected(2, kb);
    do_start(2, 1'b1, 32'h1234);
    wait_done("t5_done", 100);
    repeat (3) @(negedge clk);
    check_val("t5_reseed_cnt", 80'(reseed_cnt), 80'd1);
    check_val("t5_seed", 80'(reseed_seed), 80'h1234);
    check_val("t5_reseed_before_pop", 80'(reseed_pops - pb), 80'd0);
    check_val("t5_beats", 80'(beat_cnt - bb), 80'd2);

    // reset in WAIT with two entries buffered
    m_ready = 1'b0; bb = beat_cnt;
    do_start(5, 1'b0, 32'd0);
    n = 0;
    while (!(gen_pop_enable && samples_rcvd == 16'd2) && n < 60) begin
      @(negedge clk);
      n++;
    end
    check_val("t6_reached_samples", 80'(samples_rcvd), 80'd2);
    check_val("t6_reached_valid", 80'(m_valid), 80'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_val("t6_rst_m_valid", 80'(m_valid), 80'd0);
    check_val("t6_rst_busy", 80'(busy), 80'd0);
    check_val("t6_rst_pop", 80'(gen_pop_enable), 80'd0);
    repeat (6) @(posedge clk);
    #1;
    check_val("t6_late_m_valid", 80'(m_valid), 80'd0);
    check_val("t6_late_samples", 80'(samples_rcvd), 80'd0);
    check_val("t6_late_busy", 80'(busy), 80'd0);
    check_val("t6_beats", 80'(beat_cnt - bb), 80'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
